// File: rtl/axis_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// axis_read_ctrl_if
// Bundles the command, read-data config and AXI AR signals of axis_read_ctrl.
//   slave  : the controller's view (takes commands, drives config push and AR)
//   master : the environment's view (config registers, read-data block, AXI)
// Signals:
//   cfg_address/cfg_length/cfg_val/cfg_rdy    stream read command
//   data_cfg_length/data_cfg_val/data_cfg_rdy word count to read-data block
//   axi_araddr/arlen/arsize/arburst/arvalid/arready  AXI read-address channel
//   busy                                      controller not idle
// ---------------------------------------------------------------------------
interface axis_read_ctrl_if #(
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
);
    logic [CFG_DWIDTH-1:0]     cfg_address;
    logic [CFG_DWIDTH-1:0]     cfg_length;
    logic                      cfg_val;
    logic                      cfg_rdy;
    logic [CFG_DWIDTH-1:0]     data_cfg_length;
    logic                      data_cfg_val;
    logic                      data_cfg_rdy;
    logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]                axi_arlen;
    logic [2:0]                axi_arsize;
    logic [1:0]                axi_arburst;
    logic                      axi_arvalid;
    logic                      axi_arready;
    logic                      busy;

    modport slave (
        input  cfg_address, cfg_length, cfg_val, data_cfg_rdy, axi_arready,
        output cfg_rdy, data_cfg_length, data_cfg_val, axi_araddr, axi_arlen,
               axi_arsize, axi_arburst, axi_arvalid, busy
    );

    modport master (
        output cfg_address, cfg_length, cfg_val, data_cfg_rdy, axi_arready,
        input  cfg_rdy, data_cfg_length, data_cfg_val, axi_araddr, axi_arlen,
               axi_arsize, axi_arburst, axi_arvalid, busy
    );
endinterface

// File: rtl/axis_read_ctrl.sv
// ---------------------------------------------------------------------------
// axis_read_ctrl
// Sequencer in front of the AXI read path of the stream engine. Accepts one
// read command (start byte address, length in DATA_WIDTH words), pushes the
// word count to the read-data block, then splits the command into AXI INCR
// bursts of at most BURST_LEN beats on the AR channel.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  axis_read_ctrl_if.slave (command, data config push, AXI AR, busy)
// Optional feature:
//   AXIS_READ_CTRL_4K_SPLIT_EN  when defined, bursts are also clipped so that
//                               none crosses a 4 KB address boundary.
// ---------------------------------------------------------------------------
module axis_read_ctrl #(
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BURST_LEN      = 16
) (
    input logic              clk,
    input logic              rst,
    axis_read_ctrl_if.slave  bus
);

    localparam int unsigned RATIO      = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned RATIO_LOG2 = $clog2(RATIO);
    localparam int unsigned BYTES      = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2  = $clog2(BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES - 1);
    localparam logic [CFG_DWIDTH-1:0]     BURST_MAX  = CFG_DWIDTH'(BURST_LEN);

    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StLoad  = 5'b00010,
        StDcfg  = 5'b00100,
        StBurst = 5'b01000,
        StAddr  = 5'b10000
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [CFG_DWIDTH-1:0]     len_q, len_d;
    logic [CFG_DWIDTH-1:0]     beats_q, beats_d;
    logic [7:0]                n_q, n_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [7:0]                burst_n;
    logic [CFG_DWIDTH-1:0]     beats_rem;

    // Beats left once the burst currently on AR is accepted.
    assign beats_rem = beats_q - CFG_DWIDTH'(n_q);

`ifdef AXIS_READ_CTRL_4K_SPLIT_EN
    logic [12:0] page_beats;
`endif

    // Size of the next burst.
    always_comb begin
        burst_n = (beats_q < BURST_MAX) ? beats_q[7:0] : 8'(BURST_LEN);
`ifdef AXIS_READ_CTRL_4K_SPLIT_EN
        // addr_q is beat aligned, so the division by BYTES is exact.
        page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2;
        if ({5'd0, burst_n} > page_beats) begin
            burst_n = page_beats[7:0];
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.cfg_val) state_d = StLoad;
            StLoad:  state_d = (len_q == '0) ? StIdle : StDcfg;
            StDcfg:  if (bus.data_cfg_rdy) state_d = StBurst;
            StBurst: state_d = StAddr;
            StAddr:  if (bus.axi_arready) state_d = (beats_rem == '0) ? StIdle : StBurst;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        bus.cfg_rdy         = (state_q == StIdle);
        bus.data_cfg_val    = (state_q == StDcfg);
        bus.axi_arvalid     = (state_q == StAddr);
        bus.busy            = (state_q != StIdle);
        bus.data_cfg_length = len_q;
        bus.axi_araddr      = araddr_q;
        bus.axi_arlen       = arlen_q;
        bus.axi_arsize      = 3'(SIZE_LOG2);
        bus.axi_arburst     = 2'b01;
    end

    // Datapath next state.
    always_comb begin
        addr_d   = addr_q;
        araddr_d = araddr_q;
        len_d    = len_q;
        beats_d  = beats_q;
        n_d      = n_q;
        arlen_d  = arlen_q;
        if (state_q == StIdle && bus.cfg_val) begin
            // Misaligned low address bits are dropped here.
            addr_d = AXI_ADDR_WIDTH'(bus.cfg_address) & ALIGN_MASK;
            len_d  = bus.cfg_length;
        end
        if (state_q == StLoad) begin
            beats_d = (len_q + CFG_DWIDTH'(RATIO - 1)) >> RATIO_LOG2;
        end
        if (state_q == StBurst) begin
            n_d      = burst_n;
            arlen_d  = burst_n - 8'd1;
            araddr_d = addr_q;
        end
        if (state_q == StAddr && bus.axi_arready) begin
            addr_d  = addr_q + (AXI_ADDR_WIDTH'(n_q) << SIZE_LOG2);
            beats_d = beats_rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            araddr_q <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            n_q      <= '0;
            arlen_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            araddr_q <= araddr_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            n_q      <= n_d;
            arlen_q  <= arlen_d;
        end
    end

endmodule

// File: tb/tb_axis_read_ctrl.sv
module tb_axis_read_ctrl;

    localparam int unsigned CW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned ADW   = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned BL    = 16;
    localparam int unsigned RATIO = ADW / DW;
    localparam int unsigned BYTES = ADW / 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      len;
        logic [7:0]       dd;
        logic [7:0]       ad;
        logic [3:0]       n_ar;
        logic [3:0][31:0] ar_addr;
        logic [3:0][7:0]  ar_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_read_ctrl_if #(.CFG_DWIDTH(CW), .AXI_ADDR_WIDTH(AW)) bus ();

    axis_read_ctrl #(
        .CFG_DWIDTH    (CW),
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(ADW),
        .DATA_WIDTH    (DW),
        .BURST_LEN     (BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Observations gathered by the monitor for the current command.
    ar_t  got_ar[$];
    ar_t  exp_ar[$];
    int   got_dcfg_n;
    logic [31:0] got_dcfg_len;
    logic seen_dcfg_val, seen_arvalid;
    logic pend;
    ar_t  pend_ar;

    int dcfg_delay = 0;
    int ar_delay   = 0;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: walk the command beat by beat budget, burst by burst.
    function automatic void model(input logic [31:0] addr, input logic [31:0] len);
        longint a, beats, n;
        exp_ar.delete();
        a     = longint'(addr) - (longint'(addr) % BYTES);
        beats = ((longint'(len) + RATIO - 1) & 64'hFFFF_FFFF) / RATIO;
        while (beats > 0) begin
            n = (beats < BL) ? beats : BL;
`ifdef AXIS_READ_CTRL_4K_SPLIT_EN
            if ((4096 - a % 4096) / BYTES < n) n = (4096 - a % 4096) / BYTES;
`endif
            exp_ar.push_back('{addr: 32'(a), len: 8'(n - 1)});
            a     = (a + n * BYTES) % (64'd1 << 32);
            beats = beats - n;
        end
    endfunction

    // Ready drivers: hold each ready low for a programmable number of cycles.
    initial begin
        int dc, ac;
        dc = 0;
        ac = 0;
        bus.data_cfg_rdy = 1'b0;
        bus.axi_arready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.data_cfg_val) begin
                if (dc >= dcfg_delay) begin bus.data_cfg_rdy = 1'b1; dc = 0; end
                else begin bus.data_cfg_rdy = 1'b0; dc++; end
            end else begin
                bus.data_cfg_rdy = 1'b0;
                dc = 0;
            end
            if (bus.axi_arvalid) begin
                if (ac >= ar_delay) begin bus.axi_arready = 1'b1; ac = 0; end
                else begin bus.axi_arready = 1'b0; ac++; end
            end else begin
                bus.axi_arready = 1'b0;
                ac = 0;
            end
        end
    end

    // Monitor on the falling edge: records handshakes, checks protocol rules.
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.busy) check("cfg_rdy_while_busy", 64'(bus.cfg_rdy), 64'd0);
                if (bus.data_cfg_val) seen_dcfg_val = 1'b1;
                if (bus.data_cfg_val && bus.data_cfg_rdy) begin
                    got_dcfg_n++;
                    got_dcfg_len = bus.data_cfg_length;
                end
                if (bus.axi_arvalid) begin
                    seen_arvalid = 1'b1;
                    check("ar_after_dcfg", 64'(got_dcfg_n != 0), 64'd1);
                    if (pend) begin
                        check("araddr_stable", 64'(bus.axi_araddr), 64'(pend_ar.addr));
                        check("arlen_stable", 64'(bus.axi_arlen), 64'(pend_ar.len));
                    end
                    if (bus.axi_arready) begin
                        got_ar.push_back('{addr: bus.axi_araddr, len: bus.axi_arlen});
                        pend = 1'b0;
                    end else begin
                        pend    = 1'b1;
                        pend_ar = '{addr: bus.axi_araddr, len: bus.axi_arlen};
                    end
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    // Issue one command; returns one cycle after the cfg handshake edge.
    task automatic start_cmd(input logic [31:0] addr, input logic [31:0] len,
                             input int dd, input int ad);
        int c;
        dcfg_delay    = dd;
        ar_delay      = ad;
        got_ar.delete();
        got_dcfg_n    = 0;
        got_dcfg_len  = '0;
        seen_dcfg_val = 1'b0;
        seen_arvalid  = 1'b0;
        c = 0;
        while (!bus.cfg_rdy && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!bus.cfg_rdy) check("cfg_rdy_timeout", 64'(bus.cfg_rdy), 64'd1);
        bus.cfg_address = addr;
        bus.cfg_length  = len;
        bus.cfg_val     = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_val     = 1'b0;
        bus.cfg_address = $urandom;
        bus.cfg_length  = $urandom;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (bus.busy && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic compare_ars(input string name);
        check({name, "_ar_count"}, 64'(got_ar.size()), 64'(exp_ar.size()));
        for (int i = 0; i < got_ar.size() && i < exp_ar.size(); i++) begin
            check({name, "_araddr"}, 64'(got_ar[i].addr), 64'(exp_ar[i].addr));
            check({name, "_arlen"}, 64'(got_ar[i].len), 64'(exp_ar[i].len));
        end
    endtask

    task automatic run_cmd(input string name, input logic [31:0] addr, input logic [31:0] len,
                           input int dd, input int ad);
        start_cmd(addr, len, dd, ad);
        wait_idle();
        check({name, "_dcfg_pushes"}, 64'(got_dcfg_n), 64'(len != 0));
        if (len != 0) check({name, "_dcfg_len"}, 64'(got_dcfg_len), 64'(len));
        model(addr, len);
        compare_ars(name);
    endtask

    task automatic set_vec(input int i, input logic [31:0] addr, input logic [31:0] len,
                           input int dd, input int ad, input int n,
                           input logic [31:0] a0, input logic [7:0] l0,
                           input logic [31:0] a1, input logic [7:0] l1,
                           input logic [31:0] a2, input logic [7:0] l2);
        vecs[i]            = '0;
        vecs[i].addr       = addr;
        vecs[i].len        = len;
        vecs[i].dd         = 8'(dd);
        vecs[i].ad         = 8'(ad);
        vecs[i].n_ar       = 4'(n);
        vecs[i].ar_addr[0] = a0;
        vecs[i].ar_len[0]  = l0;
        vecs[i].ar_addr[1] = a1;
        vecs[i].ar_len[1]  = l1;
        vecs[i].ar_addr[2] = a2;
        vecs[i].ar_len[2]  = l2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [31:0] a, l;

        set_vec(0, 32'h1000, 64, 0, 0, 2, 32'h1000, 15, 32'h1080, 15, 0, 0);
        set_vec(1, 32'h2000, 3, 0, 0, 1, 32'h2000, 1, 0, 0, 0, 0);
`ifdef AXIS_READ_CTRL_4K_SPLIT_EN
        set_vec(2, 32'h0FC0, 64, 0, 0, 3, 32'h0FC0, 7, 32'h1000, 15, 32'h1080, 7);
        set_vec(6, 32'hFFFF_FFF0, 8, 1, 2, 2, 32'hFFFF_FFF0, 1, 32'h0000_0000, 1, 0, 0);
`else
        set_vec(2, 32'h0FC0, 64, 0, 0, 2, 32'h0FC0, 15, 32'h1040, 15, 0, 0);
        set_vec(6, 32'hFFFF_FFF0, 8, 1, 2, 1, 32'hFFFF_FFF0, 3, 0, 0, 0, 0);
`endif
        set_vec(3, 32'h4000, 64, 10, 5, 2, 32'h4000, 15, 32'h4080, 15, 0, 0);
        set_vec(4, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(5, 32'h6004, 1, 0, 0, 1, 32'h6000, 0, 0, 0, 0, 0);

        bus.cfg_address = '0;
        bus.cfg_length  = '0;
        bus.cfg_val     = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_rdy", 64'(bus.cfg_rdy), 64'd1);
        check("rst_data_cfg_val", 64'(bus.data_cfg_val), 64'd0);
        check("rst_arvalid", 64'(bus.axi_arvalid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_araddr", 64'(bus.axi_araddr), 64'd0);
        check("rst_arlen", 64'(bus.axi_arlen), 64'd0);
        check("rst_data_cfg_length", 64'(bus.data_cfg_length), 64'd0);
        check("arsize", 64'(bus.axi_arsize), 64'd3);
        check("arburst", 64'(bus.axi_arburst), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of directed commands with hand-derived burst lists.
        for (int i = 0; i < 7; i++) begin
            start_cmd(vecs[i].addr, vecs[i].len, int'(vecs[i].dd), int'(vecs[i].ad));
            wait_idle();
            check("vec_dcfg_pushes", 64'(got_dcfg_n), 64'(vecs[i].len != 0));
            if (vecs[i].len != 0) check("vec_dcfg_len", 64'(got_dcfg_len), 64'(vecs[i].len));
            check("vec_ar_count", 64'(got_ar.size()), 64'(vecs[i].n_ar));
            for (int j = 0; j < got_ar.size() && j < int'(vecs[i].n_ar); j++) begin
                check("vec_araddr", 64'(got_ar[j].addr), 64'(vecs[i].ar_addr[j]));
                check("vec_arlen", 64'(got_ar[j].len), 64'(vecs[i].ar_len[j]));
            end
            check("vec_idle_busy", 64'(bus.busy), 64'd0);
        end

        // Handshake to first arvalid takes three cycles with ready config.
        start_cmd(32'h7000, 2, 0, 0);
        c = 0;
        while (!bus.axi_arvalid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("first_ar_latency", 64'(c), 64'd3);
        wait_idle();
        check("lat_araddr", 64'(got_ar.size() > 0 ? got_ar[0].addr : 32'hDEAD), 64'h7000);

        // Zero length: no push, no AR, cfg_rdy back within two cycles.
        start_cmd(32'h5000, 0, 0, 0);
        c = 0;
        while (!bus.cfg_rdy && c < 2) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("len0_cfg_rdy", 64'(bus.cfg_rdy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("len0_no_dcfg_val", 64'(seen_dcfg_val), 64'd0);
        check("len0_no_arvalid", 64'(seen_arvalid), 64'd0);

        // Reset while an AR is pending.
        start_cmd(32'h8000, 64, 0, 20);
        c = 0;
        while (!bus.axi_arvalid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("midrst_reached_addr", 64'(bus.axi_arvalid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_arvalid", 64'(bus.axi_arvalid), 64'd0);
        check("midrst_data_cfg_val", 64'(bus.data_cfg_val), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_cfg_rdy", 64'(bus.cfg_rdy), 64'd1);
        check("midrst_araddr", 64'(bus.axi_araddr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_cmd("after_rst", 32'h3000, 2, 0, 0);
        check("after_rst_araddr", 64'(got_ar.size() > 0 ? got_ar[0].addr : 32'hDEAD), 64'h3000);
        check("after_rst_arlen", 64'(got_ar.size() > 0 ? got_ar[0].len : 8'hAA), 64'd0);

        // Randomised commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a = {a[31:12], 12'(4096 - 8 * $urandom_range(1, 20))};
            l = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4))
                                            : 32'($urandom_range(1, 300));
            run_cmd("rand", a, l, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
